dsp_logic_checker: RTL and testbench

Parametrised self-checking stimulus/compare harness for DSP logic-op designs under test (and/or/xor/nand), generalising the single-vector fixed-width checks.
- Drives two operands per cycle from internal LFSRs.
- Computes the golden result internally and delays it by the DUT's latency.
- Compares against the DUT output and reports sticky fail/finish plus an error count for the CI top level.

---
 rtl/dsp_check_pkg.sv | 31 +++
 rtl/dsp_logic_checker_if.sv | 9 +
 rtl/lfsr_galois32.sv | 29 ++
 rtl/dsp_logic_checker.sv | 137 +++++++++++++
 tb/tb_dsp_logic_checker.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/dsp_check_pkg.sv
// Shared definitions for the DSP logic-op checker: op encodings, LFSR taps,
// FSM states and the golden reference function.
package dsp_check_pkg;

    localparam logic [1:0]  OP_AND    = 2'd0;
    localparam logic [1:0]  OP_OR     = 2'd1;
    localparam logic [1:0]  OP_XOR    = 2'd2;
    localparam logic [1:0]  OP_NAND   = 2'd3;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [31:0] golden_op(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dsp_logic_checker_if.sv
// Operand/result bus between the checker (master) and the DUT (slave).
interface dsp_logic_checker_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic [WIDTH-1:0] dut_y;

    modport master (output dut_a, output dut_b, input dut_y);
    modport slave  (input dut_a, input dut_b, output dut_y);
endinterface

// File: rtl/lfsr_galois32.sv
// 32-bit right-shifting Galois LFSR; q exposes the low WIDTH bits of the state.
module lfsr_galois32
    import dsp_check_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [31:0]      seed,
    output logic [WIDTH-1:0] q
);

    logic [31:0] state;

    // Reset reloads the seed so every run replays the same sequence.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= seed;
        end else if (en) begin
            state <= state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
        end else begin
            state <= state;
        end
    end

    assign q = state[WIDTH-1:0];

endmodule

// File: rtl/dsp_logic_checker.sv
// Self-checking stimulus/compare harness: drives LFSR operands to a logic-op DUT
// and compares its output against a latency-matched golden result.
module dsp_logic_checker
    import dsp_check_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          LATENCY     = 0,
    parameter int          NUM_VECTORS = 16,
    parameter int          OP          = 0,
    parameter logic [31:0] SEED_A      = 32'd67,
    parameter logic [31:0] SEED_B      = 32'd9
) (
    input  logic                 clock,
    input  logic                 reset,
    dsp_logic_checker_if.master  bus,
    output logic [15:0]          err_count,
    output logic                 fail,
    output logic                 finish
);

    state_t           state;
    logic [31:0]      idx;
    logic [31:0]      drain_cnt;
    logic             issue;
    logic             advance;
    logic             tail_valid;
    logic             mismatch;
    logic [WIDTH-1:0] exp_y;
    logic [WIDTH-1:0] tail_exp;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;

    assign issue   = (state == RUN);
    assign advance = issue && (idx < 32'(NUM_VECTORS - 1));

    lfsr_galois32 #(.WIDTH(WIDTH)) u_lfsr_a (
        .clock (clock),
        .reset (reset),
        .en    (advance),
        .seed  (SEED_A),
        .q     (opnd_a)
    );

    lfsr_galois32 #(.WIDTH(WIDTH)) u_lfsr_b (
        .clock (clock),
        .reset (reset),
        .en    (advance),
        .seed  (SEED_B),
        .q     (opnd_b)
    );

    assign bus.dut_a = opnd_a;
    assign bus.dut_b = opnd_b;
    assign exp_y     = WIDTH'(golden_op(2'(OP), 32'(opnd_a), 32'(opnd_b)));

    generate
        if (LATENCY > 0) begin : g_pipe
            logic [LATENCY-1:0] pipe_valid;
            logic [WIDTH-1:0]   pipe_exp [LATENCY];

            // Expected values travel in step with the DUT pipeline; drain cycles push invalid slots.
            always_ff @(posedge clock) begin
                if (reset) begin
                    pipe_valid <= {LATENCY{1'b0}};
                    for (int k = 0; k < LATENCY; k++) begin
                        pipe_exp[k] <= {WIDTH{1'b0}};
                    end
                end else begin
                    pipe_valid[0] <= issue;
                    pipe_exp[0]   <= exp_y;
                    for (int k = 1; k < LATENCY; k++) begin
                        pipe_valid[k] <= pipe_valid[k-1];
                        pipe_exp[k]   <= pipe_exp[k-1];
                    end
                end
            end

            assign tail_valid = pipe_valid[LATENCY-1];
            assign tail_exp   = pipe_exp[LATENCY-1];
        end else begin : g_direct
            assign tail_valid = issue;
            assign tail_exp   = exp_y;
        end
    endgenerate

    // Valid gating keeps X on dut_y before the first real result from counting.
    assign mismatch = tail_valid && (state != DONE) && (bus.dut_y != tail_exp);

    // Issue/drain/done sequencing with sticky fail/finish and saturating error count.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            idx       <= 32'd0;
            drain_cnt <= 32'd0;
            fail      <= 1'b0;
            finish    <= 1'b0;
            err_count <= 16'd0;
        end else begin
            if (mismatch) begin
                fail <= 1'b1;
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
            case (state)
                RUN: begin
                    if (advance) begin
                        idx <= idx + 32'd1;
                    end
                    if (idx >= 32'(NUM_VECTORS - 1)) begin
                        if (LATENCY == 0) begin
                            state  <= DONE;
                            finish <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 32'(LATENCY - 1)) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 32'd1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_logic_checker.sv
// Directed bench: six checker instances (one per scenario) run side by side
// against small behavioural DUTs; checkpoints come from a table plus an LFSR model.
module tb_dsp_logic_checker;

    localparam logic [31:0] TAPS = 32'h80200003;

    logic clock;
    logic reset;
    logic rst5;

    logic        fail_w   [6];
    logic        finish_w [6];
    logic [15:0] err_w    [6];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          inst;
        int          cyc;
        logic        fail;
        logic        finish;
        logic [15:0] err;
    } chk_t;

    chk_t        tbl [$];
    logic [31:0] va  [16];
    logic [31:0] vb  [16];
    int          cnt6;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    dsp_logic_checker_if #(.WIDTH(8))  if0 ();
    dsp_logic_checker_if #(.WIDTH(8))  if1 ();
    dsp_logic_checker_if #(.WIDTH(16)) if2 ();
    dsp_logic_checker_if #(.WIDTH(16)) if3 ();
    dsp_logic_checker_if #(.WIDTH(16)) if4 ();
    dsp_logic_checker_if #(.WIDTH(8))  if5 ();

    // Behavioural DUTs
    assign if0.dut_y = if0.dut_a & if0.dut_b;
    assign if1.dut_y = if1.dut_a | if1.dut_b;

    logic [15:0] s2a, s2b, s3a, s3b, s4a, s4b;
    logic [7:0]  cnt3;
    always_ff @(posedge clock) begin
        s2a <= if2.dut_a ^ if2.dut_b;  s2b <= s2a;
        s3a <= if3.dut_a ^ if3.dut_b;  s3b <= s3a;
        s4a <= if4.dut_a ^ if4.dut_b;  s4b <= s4a;
        cnt3 <= reset ? 8'd0 : cnt3 + 8'd1;
    end
    assign if2.dut_y = s2b;
    assign if3.dut_y = s3b ^ {15'd0, (cnt3 == 8'd7)};
    assign if4.dut_y = s4b;
    assign if5.dut_y = 8'd0;

    dsp_logic_checker #(.WIDTH(8), .LATENCY(0), .NUM_VECTORS(1), .OP(0), .SEED_A(32'd67), .SEED_B(32'd9)) u_dut0 (
        .clock(clock), .reset(reset), .bus(if0), .err_count(err_w[0]), .fail(fail_w[0]), .finish(finish_w[0]));
    dsp_logic_checker #(.WIDTH(8), .LATENCY(0), .NUM_VECTORS(1), .OP(0), .SEED_A(32'd67), .SEED_B(32'd9)) u_dut1 (
        .clock(clock), .reset(reset), .bus(if1), .err_count(err_w[1]), .fail(fail_w[1]), .finish(finish_w[1]));
    dsp_logic_checker #(.WIDTH(16), .LATENCY(2), .NUM_VECTORS(16), .OP(2), .SEED_A(32'd67), .SEED_B(32'd9)) u_dut2 (
        .clock(clock), .reset(reset), .bus(if2), .err_count(err_w[2]), .fail(fail_w[2]), .finish(finish_w[2]));
    dsp_logic_checker #(.WIDTH(16), .LATENCY(2), .NUM_VECTORS(16), .OP(2), .SEED_A(32'd67), .SEED_B(32'd9)) u_dut3 (
        .clock(clock), .reset(reset), .bus(if3), .err_count(err_w[3]), .fail(fail_w[3]), .finish(finish_w[3]));
    dsp_logic_checker #(.WIDTH(16), .LATENCY(2), .NUM_VECTORS(16), .OP(2), .SEED_A(32'd67), .SEED_B(32'd9)) u_dut4 (
        .clock(clock), .reset(rst5), .bus(if4), .err_count(err_w[4]), .fail(fail_w[4]), .finish(finish_w[4]));
    dsp_logic_checker #(.WIDTH(8), .LATENCY(1), .NUM_VECTORS(16), .OP(3), .SEED_A(32'd67), .SEED_B(32'd9)) u_dut5 (
        .clock(clock), .reset(reset), .bus(if5), .err_count(err_w[5]), .fail(fail_w[5]), .finish(finish_w[5]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_cycle(input int c);
        int i;
        foreach (tbl[k]) begin
            if (tbl[k].cyc == c) begin
                chk($sformatf("fail[%0d]@%0d", tbl[k].inst, c), 32'(fail_w[tbl[k].inst]), 32'(tbl[k].fail));
                chk($sformatf("finish[%0d]@%0d", tbl[k].inst, c), 32'(finish_w[tbl[k].inst]), 32'(tbl[k].finish));
                chk($sformatf("err[%0d]@%0d", tbl[k].inst, c), 32'(err_w[tbl[k].inst]), 32'(tbl[k].err));
            end
        end
        // Scenario 3 operand sequence and fail never rising
        i = (c < 0) ? 0 : ((c > 15) ? 15 : c);
        chk($sformatf("a3@%0d", c), 32'(if2.dut_a), 32'(va[i][15:0]));
        chk($sformatf("b3@%0d", c), 32'(if2.dut_b), 32'(vb[i][15:0]));
        chk($sformatf("fail3@%0d", c), 32'(fail_w[2]), 32'd0);
        // Scenario 5 replays from seed after the mid-run reset
        if (c <= 7) i = (c < 0) ? 0 : c;
        else        i = ((c - 8) > 15) ? 15 : (c - 8);
        chk($sformatf("a5@%0d", c), 32'(if4.dut_a), 32'(va[i][15:0]));
        chk($sformatf("b5@%0d", c), 32'(if4.dut_b), 32'(vb[i][15:0]));
        if (c == 0) begin
            chk("y_and@0", 32'(if0.dut_y), 32'd1);
            chk("y_or@0", 32'(if1.dut_y), 32'd75);
        end
    endtask

    initial begin
        reset = 1'b1;
        rst5  = 1'b1;

        va[0] = 32'd67;
        vb[0] = 32'd9;
        for (int k = 1; k < 16; k++) begin
            va[k] = va[k-1][0] ? ((va[k-1] >> 1) ^ TAPS) : (va[k-1] >> 1);
            vb[k] = vb[k-1][0] ? ((vb[k-1] >> 1) ^ TAPS) : (vb[k-1] >> 1);
        end
        cnt6 = 0;
        for (int k = 0; k < 16; k++) begin
            if ((~(va[k][7:0] & vb[k][7:0])) != 8'd0) cnt6++;
        end

        // {inst, cycle, fail, finish, err_count}
        tbl.push_back('{0, -1, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{2, -1, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{5, -1, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{0,  0, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{0,  1, 1'b0, 1'b1, 16'd0});
        tbl.push_back('{0,  3, 1'b0, 1'b1, 16'd0});
        tbl.push_back('{1,  0, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{1,  1, 1'b1, 1'b1, 16'd1});
        tbl.push_back('{1,  4, 1'b1, 1'b1, 16'd1});
        tbl.push_back('{2, 17, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{2, 18, 1'b0, 1'b1, 16'd0});
        tbl.push_back('{2, 22, 1'b0, 1'b1, 16'd0});
        tbl.push_back('{3,  7, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{3,  8, 1'b1, 1'b0, 16'd1});
        tbl.push_back('{3, 17, 1'b1, 1'b0, 16'd1});
        tbl.push_back('{3, 18, 1'b1, 1'b1, 16'd1});
        tbl.push_back('{4,  6, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{4,  8, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{4, 25, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{4, 26, 1'b0, 1'b1, 16'd0});
        tbl.push_back('{5, 16, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{5, 17, (cnt6 != 0), 1'b1, 16'(cnt6)});
        tbl.push_back('{5, 20, (cnt6 != 0), 1'b1, 16'(cnt6)});
        // inst 5 at cycle 16 has a partial count; only finish matters there
        tbl[tbl.size() - 3].fail = (cnt6 - ((~(va[15][7:0] & vb[15][7:0])) != 8'd0 ? 1 : 0)) != 0;
        tbl[tbl.size() - 3].err  = 16'(cnt6 - ((~(va[15][7:0] & vb[15][7:0])) != 8'd0 ? 1 : 0));

        repeat (2) @(posedge clock);
        @(negedge clock);
        check_cycle(-1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        rst5  = 1'b0;

        for (int c = 0; c <= 30; c++) begin
            @(negedge clock);
            check_cycle(c);
            @(posedge clock);
            #1;
            if (c == 6) rst5 = 1'b1;
            if (c == 7) rst5 = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
